// File: rtl/instr_encode_pkg.sv
// Shared RV32I definitions: opcodes, instruction formats, NOP word and the
// format/immediate helpers used by the encoder and the core's decode path.
package rv32_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
    } fmt_e;

    // OP-IMM with funct3 001/101 is a shift and carries funct7 + shamt.
    function automatic fmt_e fmt_of(input logic [6:0] opcode, input logic [2:0] funct3);
        fmt_e f;
        case (opcode)
            OPC_LOAD, OPC_JALR: f = FMT_I;
            OPC_OPIMM:          f = (funct3 == 3'b001 || funct3 == 3'b101) ? FMT_SH : FMT_I;
            OPC_STORE:          f = FMT_S;
            OPC_BRANCH:         f = FMT_B;
            OPC_JAL:            f = FMT_J;
            OPC_LUI, OPC_AUIPC: f = FMT_U;
            OPC_OP:             f = FMT_R;
            default:            f = FMT_BAD;
        endcase
        return f;
    endfunction

    function automatic logic [31:0] decode_imm(input logic [31:0] instr, input fmt_e fmt);
        logic [31:0] imm;
        case (fmt)
            FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
            FMT_SH:  imm = {27'b0, instr[24:20]};
            FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm = {instr[31:12], 12'b0};
            FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'b0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/instr_encode_if.sv
// Request/response bundle of the instruction encoder; master is the
// requester/consumer side, slave is the encoder itself.
interface instr_encode_if #(parameter int CNT_W = 16);

    logic             i_valid;
    logic             o_ready;
    logic [6:0]       i_opcode;
    logic [4:0]       i_rd;
    logic [4:0]       i_rs1;
    logic [4:0]       i_rs2;
    logic [2:0]       i_funct3;
    logic [6:0]       i_funct7;
    logic [31:0]      i_imm;
    logic             o_valid;
    logic             i_ready;
    logic [31:0]      o_instr;
    logic             o_err;
    logic [CNT_W-1:0] o_cnt_ok;
    logic [CNT_W-1:0] o_cnt_err;

    modport master (
        output i_valid, i_opcode, i_rd, i_rs1, i_rs2, i_funct3, i_funct7, i_imm, i_ready,
        input  o_ready, o_valid, o_instr, o_err, o_cnt_ok, o_cnt_err
    );

    modport slave (
        input  i_valid, i_opcode, i_rd, i_rs1, i_rs2, i_funct3, i_funct7, i_imm, i_ready,
        output o_ready, o_valid, o_instr, o_err, o_cnt_ok, o_cnt_err
    );

endinterface

// File: rtl/instr_fifo.sv
// Synchronous FIFO with a registered head word so the output holds its last
// value when empty and ready/valid come purely from registered state.
module instr_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_valid,
    output logic         push_ready,
    input  logic [W-1:0] push_data,
    output logic         pop_valid,
    input  logic         pop_ready,
    output logic [W-1:0] pop_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             push;
    logic             pop;

    assign push = push_valid & push_ready;
    assign pop  = pop_valid & pop_ready;

    always_comb begin
        count_next = count + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // The next head is the entry behind the popped one, or the incoming word
    // when it lands in a FIFO that is empty after this cycle's pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            push_ready <= 1'b0;
            pop_valid  <= 1'b0;
            pop_data   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count      <= count_next;
            push_ready <= (count_next < CW'(DEPTH));
            pop_valid  <= (count_next != '0);
            if (pop) begin
                if (count > CW'(1)) begin
                    pop_data <= mem[rd_ptr + 1'b1];
                end else if (push) begin
                    pop_data <= push_data;
                end
            end else if (count == '0 && push) begin
                pop_data <= push_data;
            end
        end
    end

endmodule

// File: rtl/instr_encode.sv
// RV32I field-to-word encoder: packs and range-checks each accepted request,
// buffers {err, word} in a FIFO and counts emitted good/bad words.
module instr_encode
    import rv32_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    instr_encode_if.slave bus
);

    // Out-of-range immediates still pack their truncated bits; only err flags them.
    function automatic logic [32:0] pack_instr(
        input logic [6:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] imm
    );
        logic signed [31:0] s;
        logic [31:0]        w;
        logic               e;
        s = signed'(imm);
        w = NOP;
        e = 1'b0;
        case (fmt_of(op, f3))
            FMT_R: begin
                w = {f7, rs2, rs1, f3, rd, op};
            end
            FMT_I: begin
                w = {imm[11:0], rs1, f3, rd, op};
                e = (s < -32'sd2048) || (s > 32'sd2047);
            end
            FMT_SH: begin
                w = {f7, imm[4:0], rs1, f3, rd, op};
                e = (imm[31:5] != '0) || !(f7 == 7'b0000000 || f7 == 7'b0100000);
            end
            FMT_S: begin
                w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
                e = (s < -32'sd2048) || (s > 32'sd2047);
            end
            FMT_B: begin
                w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
                e = (s < -32'sd4096) || (s > 32'sd4094) || imm[0];
            end
            FMT_U: begin
                w = {imm[31:12], rd, op};
                e = (imm[11:0] != '0);
            end
            FMT_J: begin
                w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
                e = (s < -32'sd1048576) || (s > 32'sd1048574) || imm[0];
            end
            default: begin
                w = NOP;
                e = 1'b1;
            end
        endcase
        return {e, w};
    endfunction

    logic [32:0]      enc;
    logic [32:0]      head;
    logic             out_valid;
    logic             pop;
    logic [CNT_W-1:0] cnt_ok;
    logic [CNT_W-1:0] cnt_err;

    always_comb begin
        enc = pack_instr(bus.i_opcode, bus.i_rd, bus.i_rs1, bus.i_rs2,
                         bus.i_funct3, bus.i_funct7, bus.i_imm);
    end

    instr_fifo #(.DEPTH(DEPTH), .W(33)) u_fifo (
        .clk        (i_clk),
        .rst        (i_rst),
        .push_valid (bus.i_valid),
        .push_ready (bus.o_ready),
        .push_data  (enc),
        .pop_valid  (out_valid),
        .pop_ready  (bus.i_ready),
        .pop_data   (head)
    );

    assign pop         = out_valid & bus.i_ready;
    assign bus.o_valid = out_valid;
    assign bus.o_err   = head[32];
    assign bus.o_instr = head[31:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_ok  <= '0;
            cnt_err <= '0;
        end else if (pop) begin
            if (head[32]) begin
                if (cnt_err != '1) begin
                    cnt_err <= cnt_err + 1'b1;
                end
            end else if (cnt_ok != '1) begin
                cnt_ok <= cnt_ok + 1'b1;
            end
        end
    end

    assign bus.o_cnt_ok  = cnt_ok;
    assign bus.o_cnt_err = cnt_err;

endmodule

// File: doc/instr_encode.md
Name: instr_encode

Overview:
- Streaming RISC-V RV32I instruction encoder: the inverse of the core's immediate decode path.
- Accepts field-level requests (opcode, rd, rs1, rs2, funct3, funct7, full 32-bit immediate), range-checks the immediate, and packs the fields into a 32-bit instruction word.
- Results are buffered in a small output FIFO with valid/ready on both sides.
- Used by the self-test program generator and the boot loader to build instruction memory images.

Parameters:
- DEPTH, 2: output FIFO entries (power of 2, ≥2).
- CNT_W, 16: width of the saturating ok/error counters.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_valid  in  1  request valid.
- o_ready  out  1  request accepted when i_valid & o_ready.
- i_opcode  in  7  major opcode.
- i_rd  in  5  destination register.
- i_rs1  in  5  source register 1.
- i_rs2  in  5  source register 2.
- i_funct3  in  3  funct3.
- i_funct7  in  7  funct7; used for R-type and for OP-IMM shifts.
- i_imm  in  32  immediate as a signed/unsigned byte value, not pre-shifted.
- o_valid  out  1  output word valid.
- i_ready  in  1  consumer takes the word when o_valid & i_ready.
- o_instr  out  32  encoded instruction.
- o_err  out  1  error flag travelling with o_instr.
- o_cnt_ok  out  CNT_W  words emitted with err=0, saturating.
- o_cnt_err  out  CNT_W  words emitted with err=1, saturating.

Behaviour:
- Clock and reset:
  - Single clock domain, i_clk.
  - Reset is synchronous and active-high via i_rst.
  - While i_rst=1: FIFO flushed (o_valid=0); counters=0; o_instr=0; o_err=0; o_ready=0.
  - o_ready=1 from the first cycle after reset deasserts.
- Input handshake:
  - o_ready = (fifo count < DEPTH). It is registered state only and never depends on i_ready in the same cycle.
  - When full, a same-cycle pop does not enable a push.
- Encoding (combinational, at accept). Format is selected by opcode:
  - 0000011 LOAD: I.
  - 1100111 JALR: I.
  - 0010011 OP-IMM: I. Exception: when funct3 is 001 or 101 it is a shift, packed as {funct7, imm[4:0], rs1, funct3, rd, opcode}.
  - 0100011 STORE: S.
  - 1100011 BRANCH: B.
  - 1101111 JAL: J.
  - 0110111 LUI and 0010111 AUIPC: U; word = {imm[31:12], rd, opcode}.
  - 0110011 OP: R.
  - Standard RV32I bit placement for all formats; unused fields ignored.
- Error checks (o_err=1). The word is still packed from truncated fields:
  - I and S: imm outside [-2048, 2047].
  - B: imm outside [-4096, 4094], or imm[0]=1.
  - J: imm outside [-1048576, 1048574], or imm[0]=1.
  - U: imm[11:0] ≠ 0.
  - Shift: imm outside [0, 31], or funct7 not in {0000000, 0100000}.
  - Unknown opcode: o_instr=32'h00000013 (NOP), err=1.
- Latency:
  - A request accepted in cycle N into an empty FIFO gives o_valid=1 in cycle N+1 with the matching o_instr/o_err.
  - Order is strictly preserved.
- Output:
  - o_instr/o_err come from the FIFO head and are stable while o_valid & !i_ready.
  - A pop on o_valid & i_ready advances the head.
  - Simultaneous push and pop when not full: count unchanged, both take effect.
  - Pointers wrap modulo DEPTH.
  - When empty, o_valid=0 and o_instr/o_err hold their last value.
- Counters:
  - Incremented on pop, not on accept.
  - Saturate at all-ones and never wrap.
- Reset mid-stream: all buffered words are discarded. No partial word is ever emitted.

Decomposition:
- Shared package rv32_pkg holds:
  - opcode constants (OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_OPIMM, OPC_OP);
  - format enum {FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD};
  - the NOP constant.
- The immediate decoder moves to this package too.
- One sub-module: instr_fifo (parameterised DEPTH × 33-bit sync FIFO, word+err). Packing and range checks stay in the top level as a combinational function.

Test Plan:
- OP-IMM: opcode=0010011, rd=1, rs1=0, funct3=000, imm=5 -> o_instr=0x00500093, err=0, next cycle.
- STORE: rs1=1, rs2=2, funct3=010, imm=8 -> 0x0020A423. Shift: rd=3, rs1=4, funct3=101, funct7=0100000, imm=7 -> 0x40725193.
- BRANCH: rs1=rs2=0, funct3=000, imm=-4 -> 0xFE000EE3, err=0. Same with imm=3 -> err=1. LUI rd=5, imm=0x12345000 -> 0x123452B7. LUI imm=0x12345001 -> err=1.
- Backpressure: i_ready=0, push 3 back-to-back:
  - first two accepted, then o_ready=0 and the third is held;
  - raise i_ready: words emerge in order and the third is accepted the cycle after the first pop;
  - o_cnt_ok=3.
- Unknown opcode 1111111 -> 0x00000013, err=1, o_cnt_err increments. Counter saturation is checked with a forced CNT_W=2 build.
- Reset mid-stream: with 2 words buffered, assert i_rst for 1 cycle -> o_valid=0, counters=0, o_ready=1 the cycle after release, no stale word emitted.
